// File: rtl/sgd_add_tree_pkg.sv
// Shared types and elaboration helpers for the SGD signed adder tree with group accumulator.
package sgd_add_tree_pkg;

    localparam int unsigned MAX_W = 256;

    typedef enum logic {
        EMPTY,
        OPEN
    } grp_state_t;

    typedef struct packed {
        logic                    sat;
        logic signed [MAX_W-1:0] value;
    } sat_res_t;

    function automatic int unsigned clog2_lanes(input int unsigned n);
        int unsigned d;
        d = 0;
        for (int unsigned k = 0; k < 32; k++) begin
            if ((64'd1 << k) < 64'(n)) d = k + 1;
        end
        return d;
    endfunction

    // Lane count remaining after k pairwise reductions: ceil(n / 2**k).
    function automatic int unsigned lanes_at_level(input int unsigned n, input int unsigned k);
        return (n + (32'd1 << k) - 1) >> k;
    endfunction

    function automatic sat_res_t sat_clamp(input logic signed [MAX_W-1:0] value,
                                           input int unsigned out_w);
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        sat_res_t                r;
        hi      = (MAX_W'(1) << (out_w - 1)) - MAX_W'(1);
        lo      = ~hi;
        r.sat   = 1'b0;
        r.value = value;
        if (value > hi) begin
            r.sat   = 1'b1;
            r.value = hi;
        end else if (value < lo) begin
            r.sat   = 1'b1;
            r.value = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/sgd_add_tree_level.sv
// One registered pairwise-reduction level of the adder tree; an odd leftover lane passes through.
module sgd_add_tree_level #(
    parameter int unsigned N_IN = 2,
    parameter int unsigned W    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_IN*W-1:0]            in_data,
    output logic [((N_IN+1)/2)*W-1:0]    out_data
);

    localparam int unsigned N_OUT = (N_IN + 1) / 2;

    logic [2*N_OUT*W-1:0] padded;
    logic [N_OUT*W-1:0]   sum_d;
    logic [N_OUT*W-1:0]   sum_q;

    // Zero-padding to an even lane count turns the odd pass-through into x + 0.
    always_comb begin
        padded               = '0;
        padded[N_IN*W-1:0]   = in_data;
        sum_d                = '0;
        for (int unsigned j = 0; j < N_OUT; j++) begin
            sum_d[j*W +: W] = padded[(2*j)*W +: W] + padded[(2*j+1)*W +: W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sum_q <= '0;
        else     sum_q <= sum_d;
    end

    assign out_data = sum_q;

endmodule

// File: rtl/sgd_add_tree_acc.sv
// Pipelined masked signed adder tree with optional per-group accumulation and output saturation.
module sgd_add_tree_acc
    import sgd_add_tree_pkg::*;
#(
    parameter int unsigned NUM_IN = 8,
    parameter int unsigned IN_W   = 32,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_IN*IN_W-1:0] in_data,
    input  logic [NUM_IN-1:0]      in_enable,
    input  logic                   in_valid,
    input  logic                   in_last,
    input  logic                   in_acc,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_valid,
    output logic [CNT_W-1:0]       out_cnt,
    output logic                   out_sat,
    output logic                   out_drop
);

    localparam int unsigned D  = clog2_lanes(NUM_IN);
    localparam int unsigned TW = IN_W + D;
    localparam int unsigned AW = TW + CNT_W;
    localparam logic [CNT_W-1:0] CNT_FORCE = {{(CNT_W-1){1'b1}}, 1'b0};

    logic [NUM_IN*TW-1:0] lanes_in;
    logic signed [TW-1:0] tree_sum;

    always_comb begin
        lanes_in = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (in_enable[i])
                lanes_in[i*TW +: TW] = {{D{in_data[i*IN_W + IN_W - 1]}}, in_data[i*IN_W +: IN_W]};
        end
    end

    for (genvar k = 0; k < D; k++) begin : g_lvl
        localparam int unsigned NI = lanes_at_level(NUM_IN, k);
        localparam int unsigned NO = lanes_at_level(NUM_IN, k + 1);
        logic [NO*TW-1:0] q;
        if (k == 0) begin : g_first
            sgd_add_tree_level #(.N_IN(NI), .W(TW)) u_level (
                .clk      (clk),
                .rst      (rst),
                .in_data  (lanes_in),
                .out_data (q)
            );
        end else begin : g_next
            sgd_add_tree_level #(.N_IN(NI), .W(TW)) u_level (
                .clk      (clk),
                .rst      (rst),
                .in_data  (g_lvl[k-1].q),
                .out_data (q)
            );
        end
    end

    assign tree_sum = g_lvl[D-1].q;

    logic [D-1:0] sb_vld_d, sb_vld_q;
    logic [D-1:0] sb_last_d, sb_last_q;
    logic [D-1:0] sb_acc_d, sb_acc_q;

    always_comb begin
        sb_vld_d  = D'({sb_vld_q, in_valid});
        sb_last_d = D'({sb_last_q, in_last});
        sb_acc_d  = D'({sb_acc_q, in_acc});
    end

    logic signed [AW-1:0] acc_sum_d, acc_sum_q;
    logic [CNT_W-1:0]     cnt_d, cnt_q;
    logic [OUT_W-1:0]     out_data_d, out_data_q;
    logic [CNT_W-1:0]     out_cnt_d, out_cnt_q;
    logic                 out_valid_d, out_valid_q;
    logic                 out_sat_d, out_sat_q;
    logic                 out_drop_d, out_drop_q;

    grp_state_t           state;
    logic signed [AW-1:0] tree_ext;
    logic signed [AW-1:0] acc_total;
    logic signed [AW-1:0] emit_val;
    logic [CNT_W-1:0]     emit_cnt;
    logic                 emit;
    sat_res_t             clamp;
    logic                 clamp_hi_unused;

    // The group FSM state is implied by the beat counter: any counted beat means a group is open.
    always_comb begin
        state      = (cnt_q != '0) ? OPEN : EMPTY;
        tree_ext   = {{CNT_W{tree_sum[TW-1]}}, tree_sum};
        acc_total  = acc_sum_q + tree_ext;
        acc_sum_d  = acc_sum_q;
        cnt_d      = cnt_q;
        emit       = 1'b0;
        emit_val   = '0;
        emit_cnt   = '0;
        out_drop_d = 1'b0;
        if (sb_vld_q[D-1]) begin
            if (!sb_acc_q[D-1]) begin
                emit       = 1'b1;
                emit_val   = tree_ext;
                emit_cnt   = CNT_W'(1);
                out_drop_d = (state == OPEN);
                acc_sum_d  = '0;
                cnt_d      = '0;
            end else if (sb_last_q[D-1] || (cnt_q == CNT_FORCE)) begin
                emit      = 1'b1;
                emit_val  = acc_total;
                emit_cnt  = cnt_q + CNT_W'(1);
                acc_sum_d = '0;
                cnt_d     = '0;
            end else begin
                acc_sum_d = acc_total;
                cnt_d     = cnt_q + CNT_W'(1);
            end
        end

        clamp           = sat_clamp({{(MAX_W-AW){emit_val[AW-1]}}, emit_val}, OUT_W);
        clamp_hi_unused = ^clamp.value[MAX_W-1:OUT_W];
        out_valid_d     = emit;
        out_data_d      = emit ? clamp.value[OUT_W-1:0] : out_data_q;
        out_cnt_d       = emit ? emit_cnt : out_cnt_q;
        out_sat_d       = emit ? clamp.sat : out_sat_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_vld_q    <= '0;
            sb_last_q   <= '0;
            sb_acc_q    <= '0;
            acc_sum_q   <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
            out_drop_q  <= 1'b0;
        end else begin
            sb_vld_q    <= sb_vld_d;
            sb_last_q   <= sb_last_d;
            sb_acc_q    <= sb_acc_d;
            acc_sum_q   <= acc_sum_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= out_valid_d;
            out_sat_q   <= out_sat_d;
            out_drop_q  <= out_drop_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_cnt   = out_cnt_q;
    assign out_sat   = out_sat_q;
    assign out_drop  = out_drop_q;

endmodule

// File: tb/tb_sgd_add_tree_acc.sv
// Bench for sgd_add_tree_acc: 8-lane and 5-lane instances driven together, checked every cycle against a group-sum model.
module tb_sgd_add_tree_acc;

    localparam longint MAXP = 64'sd2147483647;
    localparam longint MINN = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [255:0] in_data = '0;
    logic [7:0]   in_enable = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_acc = 1'b0;

    logic [31:0] o8_data, o5_data;
    logic        o8_valid, o5_valid;
    logic [7:0]  o8_cnt, o5_cnt;
    logic        o8_sat, o5_sat;
    logic        o8_drop, o5_drop;

    always #5 clk = ~clk;

    sgd_add_tree_acc #(.NUM_IN(8), .IN_W(32), .OUT_W(32), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_enable(in_enable),
        .in_valid(in_valid), .in_last(in_last), .in_acc(in_acc),
        .out_data(o8_data), .out_valid(o8_valid), .out_cnt(o8_cnt),
        .out_sat(o8_sat), .out_drop(o8_drop)
    );

    sgd_add_tree_acc #(.NUM_IN(5), .IN_W(32), .OUT_W(32), .CNT_W(8)) dut5 (
        .clk(clk), .rst(rst), .in_data(in_data[159:0]), .in_enable(in_enable[4:0]),
        .in_valid(in_valid), .in_last(in_last), .in_acc(in_acc),
        .out_data(o5_data), .out_valid(o5_valid), .out_cnt(o5_cnt),
        .out_sat(o5_sat), .out_drop(o5_drop)
    );

    typedef struct {
        bit     v;
        longint data;
        longint cnt;
        bit     sat;
        bit     drop;
    } exp_t;

    exp_t   ring [2][4];
    longint gsum [2];
    int     gcnt [2];
    longint hdata[2];
    int     hcnt [2];
    bit     hsat [2];
    int     lane [8];
    bit [7:0] en;
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain sum of enabled lanes, groups tracked as a running total and beat count.
    function automatic exp_t model(input int d, input int n, input bit v, input bit lst, input bit ac);
        exp_t   e;
        longint s = 0;
        longint r = 0;
        int     c = 0;
        bit     fire = 0;
        for (int i = 0; i < n; i++) if (en[i]) s += longint'(lane[i]);
        e.v = 0;
        e.drop = 0;
        if (v) begin
            if (!ac) begin
                e.drop = (gcnt[d] != 0);
                gsum[d] = 0;
                gcnt[d] = 0;
                r = s; c = 1; fire = 1;
            end else begin
                gsum[d] += s;
                gcnt[d]++;
                if (lst || gcnt[d] == 255) begin
                    r = gsum[d]; c = gcnt[d]; fire = 1;
                    gsum[d] = 0; gcnt[d] = 0;
                end
            end
        end
        if (fire) begin
            e.v = 1;
            hcnt[d] = c;
            hsat[d] = 1;
            if (r > MAXP)      hdata[d] = MAXP;
            else if (r < MINN) hdata[d] = MINN;
            else begin hdata[d] = r; hsat[d] = 0; end
        end
        e.data = hdata[d];
        e.cnt  = longint'(hcnt[d]);
        e.sat  = hsat[d];
        return e;
    endfunction

    task automatic check_dut(input int d, input logic v, input logic [31:0] data,
                             input logic [7:0] cnt, input logic sat, input logic drop);
        exp_t  e = ring[d][cyc % 4];
        string p = (d == 0) ? "n8" : "n5";
        chk({p, ".valid"}, longint'(v), longint'(e.v));
        chk({p, ".data"},  longint'($signed(data)), e.data);
        chk({p, ".cnt"},   longint'(cnt), e.cnt);
        chk({p, ".sat"},   longint'(sat), longint'(e.sat));
        chk({p, ".drop"},  longint'(drop), longint'(e.drop));
    endtask

    task automatic cycle(input bit v, input bit lst, input bit ac);
        @(negedge clk);
        check_dut(0, o8_valid, o8_data, o8_cnt, o8_sat, o8_drop);
        check_dut(1, o5_valid, o5_data, o5_cnt, o5_sat, o5_drop);
        in_valid  = v;
        in_last   = lst;
        in_acc    = ac;
        in_enable = en;
        for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = lane[i];
        ring[0][cyc % 4] = model(0, 8, v, lst, ac);
        ring[1][cyc % 4] = model(1, 5, v, lst, ac);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_acc   = 1'b0;
        #1;
        chk("rst.n8.valid", longint'(o8_valid), 0);
        chk("rst.n8.data",  longint'(o8_data), 0);
        chk("rst.n8.cnt",   longint'(o8_cnt), 0);
        chk("rst.n8.sat",   longint'(o8_sat), 0);
        chk("rst.n8.drop",  longint'(o8_drop), 0);
        chk("rst.n5.valid", longint'(o5_valid), 0);
        chk("rst.n5.data",  longint'(o5_data), 0);
        for (int d = 0; d < 2; d++) begin
            gsum[d] = 0; gcnt[d] = 0; hdata[d] = 0; hcnt[d] = 0; hsat[d] = 0;
            for (int i = 0; i < 4; i++) ring[d][i] = '{v: 0, data: 0, cnt: 0, sat: 0, drop: 0};
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic lanes_seq();
        for (int i = 0; i < 8; i++) lane[i] = i + 1;
        en = 8'hFF;
    endtask

    initial begin
        lanes_seq();
        do_reset();

        // pass mode, also 5-lane instance
        cycle(1'b1, 1'b0, 1'b0);
        idle(4);
        chk("pass.valid", longint'(o8_valid), 1);
        chk("pass.data",  longint'($signed(o8_data)), 36);
        chk("pass.cnt",   longint'(o8_cnt), 1);
        chk("odd5.data",  longint'($signed(o5_data)), 15);

        // mask
        for (int i = 0; i < 8; i++) lane[i] = 100;
        lane[0] = 5; lane[7] = -3; en = 8'h81;
        cycle(1'b1, 1'b0, 1'b0);
        idle(4);
        chk("mask.data", longint'($signed(o8_data)), 2);
        for (int b = 0; b < 8; b++) begin
            lane[0] = 5 + b;
            cycle(1'b1, 1'b0, 1'b0);
        end
        idle(4);
        chk("mask.b2b.last", longint'($signed(o8_data)), 9);

        // groups back to back
        lanes_seq();
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        idle(2);
        chk("grp1.valid", longint'(o8_valid), 1);
        chk("grp1.data",  longint'($signed(o8_data)), 108);
        chk("grp1.cnt",   longint'(o8_cnt), 3);
        idle(2);
        chk("grp2.data",  longint'($signed(o8_data)), 72);
        chk("grp2.cnt",   longint'(o8_cnt), 2);

        // saturation both directions
        for (int i = 0; i < 8; i++) lane[i] = 32'h7FFFFFFF;
        cycle(1'b1, 1'b0, 1'b0);
        idle(4);
        chk("satp.data", longint'($signed(o8_data)), MAXP);
        chk("satp.sat",  longint'(o8_sat), 1);
        for (int i = 0; i < 8; i++) lane[i] = 32'h80000000;
        cycle(1'b1, 1'b0, 1'b0);
        idle(4);
        chk("satn.data", longint'($signed(o8_data)), MINN);
        chk("satn.sat",  longint'(o8_sat), 1);

        // open group abandoned by a pass beat
        lanes_seq();
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) lane[i] = 0;
        lane[0] = 10; en = 8'h01;
        cycle(1'b1, 1'b0, 1'b0);
        idle(4);
        chk("drop.data", longint'($signed(o8_data)), 10);
        chk("drop.flag", longint'(o8_drop), 1);
        chk("drop.cnt",  longint'(o8_cnt), 1);

        // counter limit forces an emit at 255 beats
        lane[0] = 1; en = 8'h01;
        for (int b = 0; b < 255; b++) cycle(1'b1, 1'b0, 1'b1);
        idle(4);
        chk("force.valid", longint'(o8_valid), 1);
        chk("force.cnt",   longint'(o8_cnt), 255);
        chk("force.data",  longint'($signed(o8_data)), 255);
        cycle(1'b1, 1'b1, 1'b1);
        idle(4);
        chk("single.cnt",  longint'(o8_cnt), 1);
        chk("single.drop", longint'(o8_drop), 0);

        // reset with beats in flight
        lanes_seq();
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        do_reset();
        idle(6);
        chk("flush.valid", longint'(o8_valid), 0);
        chk("flush.data",  longint'(o8_data), 0);
        chk("flush.cnt",   longint'(o8_cnt), 0);

        // randomized traffic
        for (int t = 0; t < 10000; t++) begin
            int unsigned mode;
            mode = $urandom_range(0, 7);
            for (int i = 0; i < 8; i++) begin
                if (mode == 0)      lane[i] = ($urandom_range(0, 1) == 1) ? 32'h7FFFFFFF : 32'h80000000;
                else if (mode < 4)  lane[i] = int'($urandom_range(0, 2000)) - 1000;
                else                lane[i] = int'($urandom);
            end
            en = 8'($urandom);
            cycle($urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
